// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, status ID, configuration reset values and FSM encoding
// for the SPI command decoder.
package spi_cmd_pkg;

    localparam logic [7:0] CMD_PIXEL   = 8'h2A;
    localparam logic [7:0] CMD_CFG     = 8'h2B;
    localparam logic [7:0] CMD_REFRESH = 8'h2C;

    localparam logic [5:0] STATUS_ID   = 6'h2A;

    localparam logic [7:0] CFG_T0H_RST = 8'd18;
    localparam logic [7:0] CFG_T1H_RST = 8'd36;
    localparam logic [7:0] CFG_LEN_RST = 8'd16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_PIXEL   = 3'd2,
        ST_CFG     = 3'd3,
        ST_DISCARD = 3'd4
    } state_e;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == CMD_PIXEL) || (b == CMD_CFG) || (b == CMD_REFRESH);
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Bundles the byte stream from spi_slave and the decoder outputs so a
// bench or parent can carry them as one object.
interface spi_cmd_decoder_if #(parameter int RAM_AW = 10);

    logic              cs_n;
    logic              byte_vld;
    logic [7:0]        byte_data;
    logic [7:0]        status;
    logic              ram_wr_en;
    logic [RAM_AW-1:0] ram_wr_addr;
    logic [7:0]        ram_wr_data;
    logic [7:0]        cfg_t0h;
    logic [7:0]        cfg_t1h;
    logic [7:0]        cfg_len;
    logic              frame_rdy;

    // Handshake: byte_data is meaningful only in a cycle where byte_vld=1;
    // there is no back-pressure, every vld byte is consumed in that cycle.
    modport master (
        output cs_n, byte_vld, byte_data,
        input  status, ram_wr_en, ram_wr_addr, ram_wr_data,
               cfg_t0h, cfg_t1h, cfg_len, frame_rdy
    );

    modport slave (
        input  cs_n, byte_vld, byte_data,
        output status, ram_wr_en, ram_wr_addr, ram_wr_data,
               cfg_t0h, cfg_t1h, cfg_len, frame_rdy
    );

endinterface

// File: rtl/spi_cmd_decoder_cs_sync.sv
// Two-flop synchroniser for the raw SPI chip select plus edge detection
// on the synchronised value.
module cs_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic cs_n_i,
    output logic cs_fall_o,
    output logic cs_rise_o
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], cs_n_i};
        prev_d = sync_q[1];
    end

    // Reset to "deselected" so a chip select already high produces no edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign cs_fall_o =  prev_q & ~sync_q[1];
    assign cs_rise_o = ~prev_q &  sync_q[1];

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command frames into pixel RAM writes, WS2812 timing
// configuration and refresh requests.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int RAM_AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_byte_vld_i,
    input  logic [7:0]        spi_byte_data_i,
    output logic [7:0]        spi_byte_data_o,
    output logic              ram_wr_en_o,
    output logic [RAM_AW-1:0] ram_wr_addr_o,
    output logic [7:0]        ram_wr_data_o,
    output logic [7:0]        cfg_t0h_o,
    output logic [7:0]        cfg_t1h_o,
    output logic [7:0]        cfg_len_o,
    output logic              frame_rdy_o,
    output logic [2:0]        dbg_state_o
);

    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] CMD     = ST_CMD;
    localparam logic [2:0] PIXEL   = ST_PIXEL;
    localparam logic [2:0] CFG     = ST_CFG;
    localparam logic [2:0] DISCARD = ST_DISCARD;

    localparam logic [RAM_AW-1:0] ADDR_MAX = {RAM_AW{1'b1}};

    logic cs_fall, cs_rise;

    logic [2:0]        state_q, state_d;
    logic [RAM_AW-1:0] addr_q, addr_d;
    logic              full_q, full_d;
    logic [1:0]        idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [RAM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_q, frame_d;
    logic              ovf_q, ovf_d;
    logic              unk_q, unk_d;
    logic [7:0]        t0h_q, t0h_d;
    logic [7:0]        t1h_q, t1h_d;
    logic [7:0]        len_q, len_d;

    cs_sync u_cs_sync (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .cs_n_i    (spi_cs_n_i),
        .cs_fall_o (cs_fall),
        .cs_rise_o (cs_rise)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        full_d    = full_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        frame_d   = 1'b0;
        ovf_d     = ovf_q;
        unk_d     = unk_q;
        t0h_d     = t0h_q;
        t1h_d     = t1h_q;
        len_d     = len_q;

        if (spi_byte_vld_i) begin
            case (state_q)
                CMD: begin
                    unk_d = ~is_opcode(spi_byte_data_i);
                    case (spi_byte_data_i)
                        CMD_PIXEL: begin
                            state_d = PIXEL;
                            addr_d  = '0;
                            full_d  = 1'b0;
                            ovf_d   = 1'b0;
                        end
                        CMD_CFG: begin
                            state_d = CFG;
                            idx_d   = 2'd0;
                        end
                        CMD_REFRESH: begin
                            state_d = DISCARD;
                            frame_d = 1'b1;
                        end
                        default: state_d = DISCARD;
                    endcase
                end
                PIXEL: begin
                    // full_q marks that the last address was written; later
                    // bytes are dropped rather than wrapping onto address 0.
                    if (full_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = spi_byte_data_i;
                        if (addr_q == ADDR_MAX) full_d = 1'b1;
                        else                    addr_d = addr_q + RAM_AW'(1);
                    end
                end
                CFG: begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0:    t0h_d = spi_byte_data_i;
                        2'd1:    t1h_d = spi_byte_data_i;
                        default: begin
                            len_d   = spi_byte_data_i;
                            state_d = DISCARD;
                        end
                    endcase
                end
                default: ;
            endcase
        end

        // Chip-select edges override the byte-driven transition; the byte
        // itself has already been acted on above.
        if (cs_rise) state_d = IDLE;
        if (cs_fall) state_d = CMD;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            full_q    <= 1'b0;
            idx_q     <= 2'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            frame_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unk_q     <= 1'b0;
            t0h_q     <= CFG_T0H_RST;
            t1h_q     <= CFG_T1H_RST;
            len_q     <= CFG_LEN_RST;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            full_q    <= full_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            frame_q   <= frame_d;
            ovf_q     <= ovf_d;
            unk_q     <= unk_d;
            t0h_q     <= t0h_d;
            t1h_q     <= t1h_d;
            len_q     <= len_d;
        end
    end

    assign spi_byte_data_o = {ovf_q, unk_q, STATUS_ID};
    assign ram_wr_en_o     = wr_en_q;
    assign ram_wr_addr_o   = wr_addr_q;
    assign ram_wr_data_o   = wr_data_q;
    assign cfg_t0h_o       = t0h_q;
    assign cfg_t1h_o       = t1h_q;
    assign cfg_len_o       = len_q;
    assign frame_rdy_o     = frame_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Frame-level bench for spi_cmd_decoder: a small reference model predicts
// RAM writes into a queue and status/config/refresh results per frame.
module tb_spi_cmd_decoder;
    import spi_cmd_pkg::*;

    localparam int AW = 2;
    localparam int W  = AW + 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_decoder_if #(.RAM_AW(AW)) bus ();
    logic [2:0] dbg_state;

    spi_cmd_decoder #(.RAM_AW(AW)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .spi_cs_n_i      (bus.cs_n),
        .spi_byte_vld_i  (bus.byte_vld),
        .spi_byte_data_i (bus.byte_data),
        .spi_byte_data_o (bus.status),
        .ram_wr_en_o     (bus.ram_wr_en),
        .ram_wr_addr_o   (bus.ram_wr_addr),
        .ram_wr_data_o   (bus.ram_wr_data),
        .cfg_t0h_o       (bus.cfg_t0h),
        .cfg_t1h_o       (bus.cfg_t1h),
        .cfg_len_o       (bus.cfg_len),
        .frame_rdy_o     (bus.frame_rdy),
        .dbg_state_o     (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int frame_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   pay_q[$];

    logic       m_ovf, m_unk;
    logic [7:0] m_t0h, m_t1h, m_len;
    int         m_frames;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (bus.ram_wr_en === 1'b1) begin
            exp_w = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h8000_0000;
            check_eq("ram_wr", 32'({bus.ram_wr_addr, bus.ram_wr_data}), exp_w);
        end
        if (bus.frame_rdy === 1'b1) frame_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.byte_vld  = 1'b1;
        bus.byte_data = b;
        @(negedge clk);
        bus.byte_vld  = 1'b0;
        bus.byte_data = 8'h00;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_ovf = 1'b0;
        m_unk = 1'b0;
        m_t0h = 8'd18;
        m_t1h = 8'd36;
        m_len = 8'd16;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        check_eq({tag, "_status"}, 32'(bus.status), 32'({m_ovf, m_unk, 6'h2A}));
        check_eq({tag, "_t0h"}, 32'(bus.cfg_t0h), 32'(m_t0h));
        check_eq({tag, "_t1h"}, 32'(bus.cfg_t1h), 32'(m_t1h));
        check_eq({tag, "_len"}, 32'(bus.cfg_len), 32'(m_len));
        check_eq({tag, "_frames"}, 32'(frame_cnt), 32'(m_frames));
        check_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // One CS-low frame: opcode followed by the bytes queued in pay_q.
    task automatic run_frame(input string tag, input logic [7:0] op);
        int a;
        a = 0;
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        if (op == 8'h2A || op == 8'h2B || op == 8'h2C) m_unk = 1'b0;
        else                                           m_unk = 1'b1;
        if (op == 8'h2A) m_ovf = 1'b0;
        if (op == 8'h2C) m_frames++;
        send_byte(op);
        for (int i = 0; i < pay_q.size(); i++) begin
            if (op == 8'h2A) begin
                if (a < (1 << AW)) exp_q.push_back({AW'(a), pay_q[i]});
                else               m_ovf = 1'b1;
                a++;
            end else if (op == 8'h2B) begin
                if (i == 0) m_t0h = pay_q[i];
                if (i == 1) m_t1h = pay_q[i];
                if (i == 2) m_len = pay_q[i];
            end
            send_byte(pay_q[i]);
        end
        pay_q.delete();
        repeat (2) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.cs_n      = 1'b1;
        bus.byte_vld  = 1'b0;
        bus.byte_data = 8'h00;
        m_frames      = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check_outputs("reset");
        check_eq("reset_wr_en", 32'(bus.ram_wr_en), 32'd0);
        check_eq("reset_wr_addr", 32'(bus.ram_wr_addr), 32'd0);
        check_eq("reset_wr_data", 32'(bus.ram_wr_data), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        pay_q = '{8'h2B, 8'h00, 8'h00, 8'h00};
        run_frame("pixel4", 8'h2A);

        pay_q = '{8'h0A, 8'h14, 8'h40, 8'h55};
        run_frame("cfg", 8'h2B);

        pay_q = '{8'h2A, 8'h11};
        run_frame("refresh", 8'h2C);

        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_frame("overflow", 8'h2A);
        check_eq("ovf_status", 32'(bus.status), 32'h0000_00AA);

        pay_q = '{8'hC3};
        run_frame("ovf_clear", 8'h2A);

        pay_q = '{8'h2A, 8'h01};
        run_frame("unknown", 8'h99);
        check_eq("unk_status", 32'(bus.status), 32'h0000_006A);

        run_frame("unk_clear", 8'h2C);

        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) pay_q.push_back(8'($urandom_range(0, 255)));
            run_frame("rand_px", 8'h2A);
        end

        // Mid-frame reset: two pixels land, a third is in flight as reset hits.
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h2A);
        exp_q.push_back({AW'(0), 8'h5A});
        send_byte(8'h5A);
        exp_q.push_back({AW'(1), 8'hA5});
        send_byte(8'hA5);
        @(negedge clk);
        bus.byte_vld  = 1'b1;
        bus.byte_data = 8'h77;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("midrst");
        check_eq("midrst_wr_en", 32'(bus.ram_wr_en), 32'd0);
        check_eq("midrst_wr_addr", 32'(bus.ram_wr_addr), 32'd0);
        check_eq("midrst_wr_data", 32'(bus.ram_wr_data), 32'd0);
        check_eq("midrst_frame", 32'(bus.frame_rdy), 32'd0);
        @(negedge clk);
        bus.byte_vld  = 1'b0;
        bus.byte_data = 8'h00;
        bus.cs_n      = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_outputs("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, meaning the pixel RAM address width (2^RAM_AW bytes).
REQ-002 SHALL have port clk_i, input, 1, system clock (the same clock as spi_slave).
REQ-003 SHALL have port rst_n_i, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port spi_cs_n_i, input, 1, raw SPI chip select, asynchronous to clk_i.
REQ-005 SHALL have port spi_byte_vld_i, input, 1, one-cycle pulse meaning a received byte is valid.
REQ-006 SHALL have port spi_byte_data_i, input, 8, received byte; valid only when spi_byte_vld_i=1.
REQ-007 SHALL have port spi_byte_data_o, output, 8, status byte returned to spi_slave for MISO shifting.
REQ-008 SHALL have port ram_wr_en_o, output, 1, pixel RAM write strobe.
REQ-009 SHALL have port ram_wr_addr_o, output, RAM_AW, pixel RAM write address.
REQ-010 SHALL have port ram_wr_data_o, output, 8, pixel RAM write data.
REQ-011 SHALL have port cfg_t0h_o, output, 8, WS2812 T0H time in clk_i cycles.
REQ-012 SHALL have port cfg_t1h_o, output, 8, WS2812 T1H time in clk_i cycles.
REQ-013 SHALL have port cfg_len_o, output, 8, LED count divided by 4.
REQ-014 SHALL have port frame_rdy_o, output, 1, one-cycle refresh-request pulse.

Function
REQ-015 SHALL synchronise spi_cs_n_i with a two-flop synchroniser and detect its falling and rising edges from the synchronised value.
REQ-016 SHALL implement the FSM states IDLE, CMD, PIXEL, CFG and DISCARD.
REQ-017 SHALL go from IDLE to CMD on a synchronised CS falling edge; vld bytes received in IDLE are ignored.
REQ-018 SHALL decode the first vld byte in CMD as follows: 0x2A -> PIXEL with address cleared to 0 and the ovf flag cleared; 0x2B -> CFG with index cleared to 0; 0x2C -> one frame_rdy_o pulse, then DISCARD; any other value -> set the unk flag, then DISCARD.
REQ-019 SHALL, in PIXEL, register each vld byte: ram_wr_en_o=1 for exactly one cycle, one cycle after the vld, with ram_wr_data_o = the byte and ram_wr_addr_o = the current address; the address then increments.
REQ-020 SHALL, in PIXEL at address 2^RAM_AW-1 after that write, drop all further bytes: no write, no address wrap, and the sticky ovf flag is set.
REQ-021 SHALL, in CFG, write the vld bytes at index 0, 1 and 2 to cfg_t0h_o, cfg_t1h_o and cfg_len_o respectively, each updated one cycle after its vld, then go to DISCARD.
REQ-022 SHALL make DISCARD ignore all bytes until CS rises.
REQ-023 SHALL return from any state to IDLE on a synchronised CS rising edge; a vld arriving in the same cycle is processed first.
REQ-024 SHALL drive spi_byte_data_o = {ovf, unk, 6'h2A} as a register; unk clears on the next valid opcode.
REQ-025 SHALL make a CS falling edge while not in IDLE (a missed rising edge) force CMD.

Reset
REQ-026 SHALL, while rst_n_i=0, clear immediately: state=IDLE, synchroniser=2'b11, address=0, ram_wr_en_o=0, ram_wr_addr_o=0, ram_wr_data_o=0, frame_rdy_o=0, ovf=0, unk=0.
REQ-027 SHALL reset cfg_t0h_o to 8'd18, cfg_t1h_o to 8'd36 and cfg_len_o to 8'd16; spi_byte_data_o therefore resets to 8'h2A.
REQ-028 SHALL abort any frame on a mid-frame reset, with no write strobe issued after reset assertion.

Structure
REQ-029 SHALL define in package spi_cmd_pkg the opcode constants CMD_PIXEL=8'h2A, CMD_CFG=8'h2B and CMD_REFRESH=8'h2C, the state enum, and the status ID 6'h2A.
REQ-030 SHALL implement the CS synchroniser and edge detector as sub-module cs_sync.

Verification
REQ-031 SHALL cover: CS low, bytes 0x2A,0x2B,0x00,0x00,0x00, CS high -> writes addr0=0x2B and addr1..3=0x00, then state IDLE, ovf=0.
REQ-032 SHALL cover: 0x2B,0x0A,0x14,0x40 -> cfg_t0h_o=10, cfg_t1h_o=20, cfg_len_o=64; a following byte 0x55 changes nothing.
REQ-033 SHALL cover: 0x2C -> exactly one frame_rdy_o pulse; further bytes in the same frame produce no pulse and no writes.
REQ-034 SHALL cover: RAM_AW=2, 0x2A plus 6 bytes -> 4 writes (addr0..3) and spi_byte_data_o=8'hAA; the next 0x2A frame restores 8'h2A.
REQ-035 SHALL cover: opcode 0x99 -> no writes, spi_byte_data_o=8'h6A; a subsequent 0x2C frame clears unk.
REQ-036 SHALL cover: rst_n_i asserted after the 2nd pixel byte -> all outputs at reset values within the same cycle, and no write strobe afterwards.
